// File: rtl/wptr_ctrl_if.sv
// Write-side pointer controller bus: FIFO write request, read pointer input and status outputs.
// master drives the requests, slave is the controller.
interface wptr_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              w_en;
  logic [ADDR_W:0]   g_rptr_in;
  logic [ADDR_W:0]   af_thresh;
  logic              ovf_clr;
  logic              wr_accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   b_wptr;
  logic [ADDR_W:0]   g_wptr;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   free_cnt;
  logic              overflow;

  modport master (
    output w_en, g_rptr_in, af_thresh, ovf_clr,
    input  wr_accept, waddr, b_wptr, g_wptr, full, almost_full, free_cnt, overflow
  );

  modport slave (
    input  w_en, g_rptr_in, af_thresh, ovf_clr,
    output wr_accept, waddr, b_wptr, g_wptr, full, almost_full, free_cnt, overflow
  );
endinterface

// File: rtl/wptr_ctrl.sv
// Async FIFO write-pointer controller: binary/Gray pointers, full, free count, almost-full, overflow.
// Define WPTR_SYNC_EN to add a SYNC_STAGES-deep synchroniser on the incoming Gray read pointer.
module wptr_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic        wclk,
  input logic        wrst,
  wptr_ctrl_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0] g_rs;
  logic [PW-1:0] b_rs;
  logic          accept;
  logic [PW-1:0] b_wptr_q, b_wptr_d;
  logic [PW-1:0] g_wptr_q, g_wptr_d;
  logic [PW-1:0] free_q, free_d;
  logic [PW-1:0] used_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;

`ifdef WPTR_SYNC_EN
  logic [PW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.g_rptr_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_rs = sync_q[SYNC_STAGES-1];
`else
  assign g_rs = bus.g_rptr_in;
`endif

  always_comb begin
    b_rs         = '0;
    b_rs[ADDR_W] = g_rs[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b_rs[i] = b_rs[i+1] ^ g_rs[i];
  end

  assign accept = bus.w_en & ~full_q;

  // Full is judged on the post-write pointer so the filling write raises it on the same edge.
  always_comb begin
    b_wptr_d = b_wptr_q + PW'(accept);
    g_wptr_d = b_wptr_d ^ (b_wptr_d >> 1);
    full_d   = (g_wptr_d == {~g_rs[ADDR_W:ADDR_W-1], g_rs[ADDR_W-2:0]});
    used_d   = b_wptr_d - b_rs;
    free_d   = DEPTH - used_d;
    af_d     = (free_d <= bus.af_thresh);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.w_en & full_q) ovf_d = 1'b1;
    else if (bus.ovf_clr)  ovf_d = 1'b0;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      full_q   <= 1'b0;
      free_q   <= DEPTH;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      full_q   <= full_d;
      free_q   <= free_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.wr_accept   = accept;
  assign bus.waddr       = b_wptr_q[ADDR_W-1:0];
  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.full        = full_q;
  assign bus.free_cnt    = free_q;
  assign bus.almost_full = af_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: doc/wptr_ctrl.md
# wptr_ctrl

Parametrised write-side pointer controller for the asynchronous FIFOs in the DDR controller datapath. It keeps binary and Gray write pointers, generates a registered `full` flag, and adds a free-space count, a programmable almost-full flag and a sticky overflow flag. The read pointer arrives Gray-coded from the read domain, optionally through an internal synchroniser. The block sits in the write clock domain, beside the FIFO RAM write port.

## Interface
- `ADDR_W`, 5, RAM address width; FIFO depth `DEPTH` = 2^ADDR_W; pointers are ADDR_W+1 bits.
- `SYNC_STAGES`, 2, flop stages on `g_rptr_in`; legal range 2..4; used only with `WPTR_SYNC_EN`.
- `wclk`  in  1  write clock.
- `wrst`  in  1  reset; asynchronous, active-high.
- `w_en`  in  1  write request.
- `g_rptr_in`  in  ADDR_W+1  Gray read pointer.
- `af_thresh`  in  ADDR_W+1  almost-full threshold, in free entries; quasi-static.
- `ovf_clr`  in  1  clears `overflow`.
- `wr_accept`  out  1  combinational: `w_en & ~full`; write strobe to the RAM.
- `waddr`  out  ADDR_W  RAM write address: `b_wptr[ADDR_W-1:0]`.
- `b_wptr`  out  ADDR_W+1  binary write pointer, registered.
- `g_wptr`  out  ADDR_W+1  Gray write pointer, registered; crosses to the read domain.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered; high when `free_cnt` <= `af_thresh`.
- `free_cnt`  out  ADDR_W+1  registered free entries, 0..DEPTH.
- `overflow`  out  1  sticky; set by a write attempt while full.

## Operation
- Synchronised read pointer `g_rs`: the last synchroniser stage with `WPTR_SYNC_EN`, otherwise `g_rptr_in` directly.
- Binary read pointer `b_rs`: Gray-to-binary prefix XOR, `b_rs[i]` = XOR of `g_rs[ADDR_W:i]`.
- Next-state logic:
  - `b_next` = `b_wptr` + `wr_accept`, modulo 2^(ADDR_W+1).
  - `g_next` = `b_next ^ (b_next >> 1)`.
  - `full_next` = (`g_next` == {~`g_rs[ADDR_W:ADDR_W-1]`, `g_rs[ADDR_W-2:0]`}).
  - `used_next` = (`b_next` − `b_rs`), modulo 2^(ADDR_W+1).
  - `free_next` = `DEPTH` − `used_next`.
  - `af_next` = (`free_next` <= `af_thresh`).
- Every rising `wclk` edge registers all next values into `b_wptr`, `g_wptr`, `full`, `free_cnt` and `almost_full`.
- Because `full` is computed from the next pointer, it rises on the same edge as the write that fills the last entry, so no write is ever accepted into a full FIFO.
- Overflow:
  - `w_en & full` sets `overflow` on the next edge; the pointers do not move.
  - `ovf_clr` clears it on the next edge.
  - If both occur in the same cycle, set wins.
- Wrap-around: the extra MSB toggles every DEPTH writes. Pointers wrap from 2^(ADDR_W+1)−1 to 0 with no special case.
- Read lag: `free_cnt` and `full` are conservative. They never report more space than actually exists.
- Reset:
  - Asserting `wrst` at any time, including mid-burst, immediately clears `b_wptr`, `g_wptr`, `full`, `almost_full`, `overflow` and all synchroniser stages.
  - `free_cnt` resets to `DEPTH`.
  - After reset, `almost_full` = 0 even if `af_thresh` >= `DEPTH`; it takes its computed value from the first clock edge on.
  - The read side must be reset together with this block.

## Timing
- `wr_accept` and `waddr` are valid in the same cycle as `w_en`.
- Pointers, `full`, `free_cnt` and `almost_full` update 1 edge after an accepted write.
- A change on `g_rptr_in` reaches `full`, `free_cnt` and `almost_full` after SYNC_STAGES+1 edges with `WPTR_SYNC_EN`, or after 1 edge without it.
- `g_wptr` changes by at most one bit per cycle and is driven straight from a flop, so it is safe for crossing into the read domain.
- `overflow` sets or clears 1 edge after its cause.

## Configuration
- `WPTR_SYNC_EN` defined: `g_rptr_in` is taken raw from the read domain and passed through a `SYNC_STAGES`-deep flop chain clocked by `wclk` and reset by `wrst`.
- `WPTR_SYNC_EN` undefined: there is no synchroniser; `g_rptr_in` must already be synchronised to `wclk`, and `SYNC_STAGES` is ignored.

## Test plan
- Reset: assert `wrst` mid-clock -> all outputs 0 at once except `free_cnt` = 32 (`ADDR_W` = 5).
- Fill: read pointer held at 0, 32 consecutive `w_en` cycles -> after the 32nd accepted write `full` = 1, `free_cnt` = 0, `b_wptr` = 6'b100000, `g_wptr` = 6'b110000.
- Overflow: while full, pulse `w_en` -> `wr_accept` = 0, pointers unchanged, `overflow` = 1; pulse `ovf_clr` together with `w_en` -> `overflow` stays 1; pulse `ovf_clr` alone -> `overflow` = 0.
- Almost-full: `af_thresh` = 4, empty FIFO, write 28 entries -> `almost_full` rises on the edge where `free_cnt` goes 5 -> 4 and stays 1.
- Wrap and drain: write 40 entries while the read pointer advances by Gray steps to 40 (6'b111100) -> `b_wptr` = 40, `g_wptr` = 6'b111100, and `free_cnt` = 32 after SYNC_STAGES+1 edges (`WPTR_SYNC_EN` builds) or 1 edge (non-sync builds).
- Reset mid-operation: assert `wrst` while `full` = 1 and `overflow` = 1 -> both clear at once; after release, the first write gives `b_wptr` = 1 and `free_cnt` = 31.
